// File: rtl/cos_engine_arbiter.sv
// Two-channel round-robin front end for a single shared cosine engine.
// Optional watchdog abort is built when COS_ARB_TIMEOUT_EN is defined.

// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no job in engine; grants a pending channel if any
// START     | eng_start pulse, operands on eng_x/eng_y
// WAIT_LOW  | waiting for the engine to drop eng_ready (job taken)
// WAIT_HIGH | waiting for eng_ready to return; captures eng_w
// DONE      | done pulse for the granted channel, pointer update
module cos_engine_arbiter #(
  parameter int WIDTH       = 16,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res_w,
  output logic             err,
  output logic             busy,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_x,
  output logic [WIDTH-1:0] eng_y,
  input  logic             eng_ready,
  input  logic [WIDTH-1:0] eng_w
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             grant;
  logic             grant_nxt;
  logic             load;
  logic             ptr;
  logic [1:0]       pend;
  logic [1:0]       clr;
  logic [1:0]       acc;
  logic [WIDTH-1:0] xr0;
  logic [WIDTH-1:0] yr0;
  logic [WIDTH-1:0] xr1;
  logic [WIDTH-1:0] yr1;
  logic             tc;

  // A channel finishing this cycle frees its slot for a same-cycle request.
  assign clr    = (state == DONE) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign acc[0] = req0 & (~pend[0] | clr[0]);
  assign acc[1] = req1 & (~pend[1] | clr[1]);

  assign busy      = (state != IDLE);
  assign eng_start = (state == START);
  assign done0     = (state == DONE) & ~grant;
  assign done1     = (state == DONE) & grant;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) begin
          state_nxt = START;
          load      = 1'b1;
          grant_nxt = (pend == 2'b11) ? ptr : pend[1];
        end
      end
      START:     state_nxt = WAIT_LOW;
      WAIT_LOW: begin
        if (tc)              state_nxt = DONE;
        else if (!eng_ready) state_nxt = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (eng_ready || tc) state_nxt = DONE;
      end
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= 1'b0;
      ptr   <= 1'b0;
      pend  <= 2'b00;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      xr0   <= '0;
      yr0   <= '0;
      xr1   <= '0;
      yr1   <= '0;
      eng_x <= '0;
      eng_y <= '0;
      res_w <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      pend  <= acc | (pend & ~clr);
      ack0  <= acc[0];
      ack1  <= acc[1];
      if (acc[0]) begin
        xr0 <= x0;
        yr0 <= y0;
      end
      if (acc[1]) begin
        xr1 <= x1;
        yr1 <= y1;
      end
      if (load) begin
        eng_x <= grant_nxt ? xr1 : xr0;
        eng_y <= grant_nxt ? yr1 : yr0;
      end
      if (state == WAIT_HIGH && eng_ready) res_w <= eng_w;
      if (state == DONE) ptr <= ~grant;
    end
  end

`ifdef COS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmr;
  logic             tmo_flag;
  logic             waiting;

  // Down-counter loaded in START; terminal count after TIMEOUT_CYC wait cycles.
  assign tc      = (tmr == CNT_W'(1));
  assign waiting = (state == WAIT_LOW) | (state == WAIT_HIGH);
  assign err     = (state == DONE) & tmo_flag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr      <= '0;
      tmo_flag <= 1'b0;
    end else if (state == START) begin
      tmr      <= CNT_W'(TIMEOUT_CYC);
      tmo_flag <= 1'b0;
    end else if (waiting) begin
      if (tmr != '0) tmr <= tmr - CNT_W'(1);
      if (tc && !(state == WAIT_HIGH && eng_ready)) tmo_flag <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign tc         = 1'b0;
  assign err        = 1'b0;
  assign unused_cfg = (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_cos_engine_arbiter.sv
// Bench for cos_engine_arbiter: directed scenarios plus a randomized
// transaction-level scoreboard against a behavioural engine model.
module tb_cos_engine_arbiter;

  localparam int W  = 16;
  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] x0, y0, x1, y1;
  logic         ack0, ack1, done0, done1, err, busy, eng_start;
  logic [W-1:0] res_w, eng_x, eng_y, eng_w;
  logic         eng_ready;

  int           checks = 0;
  int           errors = 0;

  int           eng_lat = 5;
  bit           eng_ovr_en = 1'b0;
  logic [W-1:0] eng_ovr_w = '0;

  cos_engine_arbiter #(.WIDTH(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .res_w(res_w), .err(err), .busy(busy), .eng_start(eng_start),
    .eng_x(eng_x), .eng_y(eng_y), .eng_ready(eng_ready), .eng_w(eng_w)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fn(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a * 16'd3) ^ b;
  endfunction

  // Engine model: drops ready when started, raises it eng_lat cycles later
  // with the result; eng_lat == 0 means it never answers.
  initial begin
    int           cnt;
    logic [W-1:0] res;
    cnt = 0;
    res = '0;
    eng_ready = 1'b1;
    eng_w = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        cnt = 0;
        eng_ready = 1'b1;
      end else if (eng_start) begin
        eng_ready = 1'b0;
        cnt = eng_lat;
        res = eng_ovr_en ? eng_ovr_w : fn(eng_x, eng_y);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_ready = 1'b1;
          eng_w = res;
        end
      end
    end
  end

  task automatic apply_reset;
    rst = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    eng_lat = 5;
    eng_ovr_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    @(negedge clk);
    checks++;
    if ({ack0, ack1, done0, done1, err, busy, eng_start} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000000", {ack0, ack1, done0, done1, err, busy, eng_start});
    end
    checks++;
    if (res_w !== '0 || eng_x !== '0 || eng_y !== '0) begin
      errors++;
      $display("FAIL reset_regs: res_w=%h eng_x=%h eng_y=%h expected 0", res_w, eng_x, eng_y);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || eng_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b eng_start=%b expected 0", busy, eng_start);
    end
  endtask

  task automatic test_single;
    int t, nst;
    bit seen;
    apply_reset;
    eng_lat = 10;
    eng_ovr_en = 1'b1;
    eng_ovr_w = 16'h00F3;
    req0 = 1'b1; x0 = 16'h010B; y0 = 16'h0066;
    @(negedge clk);
    req0 = 1'b0; x0 = 16'($urandom); y0 = 16'($urandom);
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: ack0=%b ack1=%b expected 1 0", ack0, ack1);
    end
    @(negedge clk);
    checks++;
    if (eng_start !== 1'b1 || eng_x !== 16'h010B || eng_y !== 16'h0066) begin
      errors++;
      $display("FAIL single_start: eng_start=%b x=%h y=%h expected 1 010b 0066", eng_start, eng_x, eng_y);
    end
    nst = (eng_start === 1'b1) ? 1 : 0;
    t = 0; seen = 1'b0;
    while (!seen && t < 40) begin
      @(negedge clk);
      t++;
      if (eng_start) nst++;
      if (done0 || done1) seen = 1'b1;
    end
    checks++;
    if (!seen || done0 !== 1'b1 || done1 !== 1'b0 || t != 11) begin
      errors++;
      $display("FAIL single_done: seen=%0d done0=%b done1=%b cycles=%0d expected done0 after 11", seen, done0, done1, t);
    end
    checks++;
    if (res_w !== 16'h00F3 || err !== 1'b0 || eng_x !== 16'h010B || eng_y !== 16'h0066) begin
      errors++;
      $display("FAIL single_result: res_w=%h err=%b x=%h y=%h expected 00f3 0 010b 0066", res_w, err, eng_x, eng_y);
    end
    checks++;
    if (nst != 1) begin
      errors++;
      $display("FAIL single_start_count: got %0d expected 1", nst);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b done0=%b expected 0 0", busy, done0);
    end
    eng_ovr_en = 1'b0;
  endtask

  task automatic test_rr;
    logic [W-1:0] ox[2], oy[2];
    int ns, nd, t;
    apply_reset;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 2; c++) begin
        ox[c] = 16'($urandom);
        oy[c] = 16'($urandom);
      end
      eng_lat = $urandom_range(2, 6);
      req0 = 1'b1; req1 = 1'b1;
      x0 = ox[0]; y0 = oy[0]; x1 = ox[1]; y1 = oy[1];
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      checks++;
      if (ack0 !== 1'b1 || ack1 !== 1'b1) begin
        errors++;
        $display("FAIL rr_ack pair%0d: ack0=%b ack1=%b expected 1 1", p, ack0, ack1);
      end
      ns = 0; nd = 0; t = 0;
      while (nd < 2 && t < 80) begin
        @(negedge clk);
        t++;
        if (eng_start) begin
          checks++;
          if (ns > 1) begin
            errors++;
            $display("FAIL rr_extra_start pair%0d: start #%0d expected 2 starts", p, ns);
          end else if (eng_x !== ox[ns] || eng_y !== oy[ns]) begin
            errors++;
            $display("FAIL rr_start_ops pair%0d #%0d: x=%h y=%h expected %h %h", p, ns, eng_x, eng_y, ox[ns], oy[ns]);
          end
          ns++;
        end
        if (done0 || done1) begin
          checks++;
          if (nd > 1 || {done1, done0} !== ((nd == 0) ? 2'b01 : 2'b10) || res_w !== fn(ox[nd], oy[nd]) || err !== 1'b0) begin
            errors++;
            $display("FAIL rr_done pair%0d #%0d: done1/0=%b%b res=%h err=%b expected ch%0d res=%h", p, nd, done1, done0, res_w, err, nd, fn(ox[nd], oy[nd]));
          end
          nd++;
        end
      end
      checks++;
      if (nd != 2) begin
        errors++;
        $display("FAIL rr_timeout pair%0d: got %0d dones expected 2", p, nd);
      end
    end
  endtask

  task automatic test_pending_ignore;
    logic [W-1:0] ax, ay;
    int nack, t;
    bit seen, started;
    apply_reset;
    eng_lat = $urandom_range(2, 6);
    ax = 16'($urandom); ay = 16'($urandom);
    req0 = 1'b1; x0 = ax; y0 = ay;
    nack = 0; seen = 1'b0; started = 1'b0;
    for (t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (ack0) nack++;
      if (eng_start) begin
        started = 1'b1;
        checks++;
        if (eng_x !== ax || eng_y !== ay) begin
          errors++;
          $display("FAIL pend_ops: x=%h y=%h expected %h %h", eng_x, eng_y, ax, ay);
        end
      end
      if (done0) begin
        seen = 1'b1;
        checks++;
        if (res_w !== fn(ax, ay) || err !== 1'b0) begin
          errors++;
          $display("FAIL pend_result: res=%h err=%b expected %h 0", res_w, err, fn(ax, ay));
        end
      end
      if (t < 2) begin
        req0 = 1'b1;
        x0 = ax ^ 16'h5A5A ^ 16'(t);
        y0 = ay ^ 16'hA5A5;
      end else begin
        req0 = 1'b0;
      end
    end
    checks++;
    if (nack != 1 || !seen || !started) begin
      errors++;
      $display("FAIL pend_ack_count: acks=%0d done=%0d start=%0d expected 1 1 1", nack, seen, started);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] bx, by;
    int t;
    bit seen, bad_done, bad_start;
    apply_reset;
    eng_lat = 8;
    req0 = 1'b1; x0 = 16'($urandom); y0 = 16'($urandom);
    @(negedge clk);
    req0 = 1'b0;
    seen = 1'b0;
    for (t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (eng_start) seen = 1'b1;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (!seen || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_precond: started=%0d busy=%b expected 1 1", seen, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || eng_start !== 1'b0 || done0 !== 1'b0 || ack0 !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: busy=%b start=%b done0=%b ack0=%b err=%b expected 0", busy, eng_start, done0, ack0, err);
    end
    bad_done = 1'b0; bad_start = 1'b0;
    for (t = 0; t < 14; t++) begin
      @(negedge clk);
      if (t == 2) rst = 1'b1;
      if (done0 || done1) bad_done = 1'b1;
      if (eng_start) bad_start = 1'b1;
    end
    checks++;
    if (bad_done || bad_start) begin
      errors++;
      $display("FAIL midrst_dropped: done=%0d start=%0d expected 0 0", bad_done, bad_start);
    end
    eng_lat = 3;
    bx = 16'($urandom); by = 16'($urandom);
    req1 = 1'b1; x1 = bx; y1 = by;
    @(negedge clk);
    req1 = 1'b0;
    seen = 1'b0;
    for (t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      if (done0) bad_done = 1'b1;
      if (done1) seen = 1'b1;
    end
    checks++;
    if (!seen || bad_done || res_w !== fn(bx, by) || err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_new_job: done1=%0d stray_done0=%0d res=%h expected %h", seen, bad_done, res_w, fn(bx, by));
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] ax, ay, bx, by;
    int t;
    bit seen;
    apply_reset;
    eng_lat = $urandom_range(2, 6);
    ax = 16'($urandom); ay = 16'($urandom);
    bx = ~ax; by = 16'($urandom);
    req1 = 1'b1; x1 = ax; y1 = ay;
    @(negedge clk);
    req1 = 1'b0;
    seen = 1'b0;
    for (t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
    end
    checks++;
    if (!seen || res_w !== fn(ax, ay)) begin
      errors++;
      $display("FAIL b2b_first: done1=%0d res=%h expected 1 %h", seen, res_w, fn(ax, ay));
    end
    req1 = 1'b1; x1 = bx; y1 = by;
    @(negedge clk);
    req1 = 1'b0;
    checks++;
    if (ack1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack: ack1=%b expected 1", ack1);
    end
    @(negedge clk);
    checks++;
    if (eng_start !== 1'b1 || eng_x !== bx || eng_y !== by) begin
      errors++;
      $display("FAIL b2b_start: start=%b x=%h y=%h expected 1 %h %h", eng_start, eng_x, eng_y, bx, by);
    end
    seen = 1'b0;
    for (t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
    end
    checks++;
    if (!seen || res_w !== fn(bx, by) || err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: done1=%0d res=%h err=%b expected 1 %h 0", seen, res_w, err, fn(bx, by));
    end
  endtask

`ifdef COS_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic [W-1:0] ax, ay, bx1;
    int t;
    bit seen;
    apply_reset;
    eng_lat = 3;
    ax = 16'($urandom); ay = 16'($urandom);
    req1 = 1'b1; x1 = ax; y1 = ay;
    @(negedge clk);
    req1 = 1'b0;
    seen = 1'b0;
    for (t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
    end
    eng_lat = 0;
    req0 = 1'b1; x0 = 16'($urandom); y0 = 16'($urandom);
    @(negedge clk);
    req0 = 1'b0;
    seen = 1'b0;
    for (t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (eng_start) seen = 1'b1;
    end
    seen = 1'b0;
    for (t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      if (done0 || done1) seen = 1'b1;
    end
    checks++;
    if (!seen || done0 !== 1'b1 || err !== 1'b1 || t < TO || t > TO + 2) begin
      errors++;
      $display("FAIL timeout_done: seen=%0d done0=%b err=%b cycles=%0d expected done0 err=1 at %0d..%0d", seen, done0, err, t, TO, TO + 2);
    end
    checks++;
    if (res_w !== fn(ax, ay)) begin
      errors++;
      $display("FAIL timeout_res_hold: res=%h expected %h", res_w, fn(ax, ay));
    end
    eng_lat = 3;
    bx1 = 16'($urandom);
    req0 = 1'b1; req1 = 1'b1; x0 = ~bx1; x1 = bx1;
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_pulse: err=%b expected 0", err);
    end
    seen = 1'b0;
    for (t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (eng_start) seen = 1'b1;
    end
    checks++;
    if (!seen || eng_x !== bx1) begin
      errors++;
      $display("FAIL timeout_ptr_advance: start=%0d x=%h expected ch1 x=%h", seen, eng_x, bx1);
    end
    repeat (30) @(negedge clk);
  endtask
`endif

  task automatic test_random;
    bit           mp[2], mst[2], exp_ack[2];
    int           macc[2];
    logic [W-1:0] mx[2], my[2];
    logic [W-1:0] hx, hy, exp_res, rx, ry;
    bit           mptr, infl, el0, el1, r;
    int           mg, ch, exp_done, n_acc, n_done;
    apply_reset;
    for (int c = 0; c < 2; c++) begin
      mp[c] = 1'b0; mst[c] = 1'b0; exp_ack[c] = 1'b0; macc[c] = -100;
      mx[c] = '0; my[c] = '0;
    end
    mptr = 1'b0; infl = 1'b0; mg = 0; exp_done = -1; n_acc = 0; n_done = 0;
    hx = '0; hy = '0; exp_res = '0;
    eng_lat = $urandom_range(2, 6);
    for (int it = 0; it < 900; it++) begin
      @(negedge clk);
      checks++;
      if (ack0 !== exp_ack[0] || ack1 !== exp_ack[1]) begin
        errors++;
        $display("FAIL rand_ack it%0d: ack0/1=%b%b expected %b%b", it, ack0, ack1, exp_ack[0], exp_ack[1]);
      end
      if (eng_start) begin
        el0 = mp[0] && !mst[0] && (macc[0] <= it - 2);
        el1 = mp[1] && !mst[1] && (macc[1] <= it - 2);
        checks++;
        if (infl || !(el0 || el1)) begin
          errors++;
          $display("FAIL rand_spurious_start it%0d: in_flight=%0d eligible=%0d%0d", it, infl, el0, el1);
        end else begin
          ch = (el0 && el1) ? int'(mptr) : (el1 ? 1 : 0);
          checks++;
          if (eng_x !== mx[ch] || eng_y !== my[ch]) begin
            errors++;
            $display("FAIL rand_start_ops it%0d: x=%h y=%h expected ch%0d %h %h", it, eng_x, eng_y, ch, mx[ch], my[ch]);
          end
          infl = 1'b1; mg = ch; mst[ch] = 1'b1;
          hx = eng_x; hy = eng_y;
          exp_done = it + eng_lat + 1;
          exp_res = fn(mx[ch], my[ch]);
        end
      end else if (infl) begin
        checks++;
        if (eng_x !== hx || eng_y !== hy) begin
          errors++;
          $display("FAIL rand_ops_stable it%0d: x=%h y=%h expected %h %h", it, eng_x, eng_y, hx, hy);
        end
      end
      if (done0 || done1) begin
        checks++;
        if (!infl || it != exp_done || (done0 && done1) || done1 !== (mg == 1) || err !== 1'b0 || res_w !== exp_res) begin
          errors++;
          $display("FAIL rand_done it%0d: done1/0=%b%b err=%b res=%h expected ch%0d at it%0d res=%h", it, done1, done0, err, res_w, mg, exp_done, exp_res);
        end
        if (infl) begin
          infl = 1'b0; mp[mg] = 1'b0; mst[mg] = 1'b0; mptr = (mg == 0);
          n_done++;
        end
      end else if (infl && it == exp_done) begin
        checks++;
        errors++;
        $display("FAIL rand_done_missing it%0d: no done, expected ch%0d", it, mg);
      end
      for (int c = 0; c < 2; c++) begin
        r = (it < 800) && ($urandom_range(0, 3) == 0);
        rx = 16'($urandom); ry = 16'($urandom);
        exp_ack[c] = r && !mp[c];
        if (exp_ack[c]) begin
          mp[c] = 1'b1; mst[c] = 1'b0; mx[c] = rx; my[c] = ry; macc[c] = it;
          n_acc++;
        end
        if (c == 0) begin
          req0 = r; x0 = rx; y0 = ry;
        end else begin
          req1 = r; x1 = rx; y1 = ry;
        end
      end
      eng_lat = $urandom_range(2, 6);
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (n_acc != n_done || infl || n_acc == 0) begin
      errors++;
      $display("FAIL rand_drain: accepted=%0d completed=%0d in_flight=%0d", n_acc, n_done, infl);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset;
    test_single;
    test_rr;
    test_pending_ignore;
    test_reset_mid;
    test_back_to_back;
`ifdef COS_ARB_TIMEOUT_EN
    test_timeout;
`endif
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
